// File: rtl/seg_pkg.sv
// Shared definitions for the segment-display path.
// Holds the blank code, the game's tile and glyph codes, a few letter glyphs,
// and the two-phase scan state encoding used by seg_scan_timer and seg_scan_driver.
// All glyphs are active-low with bit7 = dp and bits 6:0 = segments g..a.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Game tiles and sprite glyphs.
    localparam logic [7:0] FLAT      = 8'h77;
    localparam logic [7:0] UP_BAR    = 8'h75;
    localparam logic [7:0] DOWN_BAR  = 8'h73;
    localparam logic [7:0] DINO_UP   = 8'h94;
    localparam logic [7:0] DINO_DOWN = 8'hA3;

    // Letter glyphs for status text (GAME OVER, SCORE, ...).
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_G = 8'hC2;
    localparam logic [7:0] GLYPH_H = 8'h89;
    localparam logic [7:0] GLYPH_L = 8'hC7;
    localparam logic [7:0] GLYPH_O = 8'hC0;
    localparam logic [7:0] GLYPH_P = 8'h8C;
    localparam logic [7:0] GLYPH_R = 8'hAF;
    localparam logic [7:0] GLYPH_S = 8'h92;
    localparam logic [7:0] GLYPH_U = 8'hC1;

    // Scan phase within one digit slot.
    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the multiplexed display.
// A counter runs 0..SCAN_DIV-1 per digit slot; the first BLANK_CYC counts are
// the BLANK phase and the rest are ON. At the end of each slot the digit index
// advances, wrapping from DIGITS-1 to 0.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   phase         current scan phase
//   phase_nxt     phase for the next cycle (lets the caller register outputs
//                 that line up with the phase register)
//   digit         current slot index
//   digit_nxt     slot index for the next cycle
//   slot_end      last ON cycle of the current slot
//   frame_end     last ON cycle of digit DIGITS-1 (scan-frame boundary)
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 64,
    localparam int CW = $clog2(SCAN_DIV),
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output scan_state_e   phase,
    output scan_state_e   phase_nxt,
    output logic [DW-1:0] digit,
    output logic [DW-1:0] digit_nxt,
    output logic          slot_end,
    output logic          frame_end
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          blank_end;

    assign slot_end  = (phase == SCAN_ON) && (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (digit == DW'(DIGITS - 1));
    assign blank_end = (phase == SCAN_BLANK) && (cnt == CW'(BLANK_CYC - 1));

    // Next-state logic for the slot counter, phase and digit index.
    always_comb begin
        cnt_nxt   = cnt + CW'(1);
        phase_nxt = phase;
        digit_nxt = digit;
        case (phase)
            SCAN_BLANK: begin
                if (blank_end) begin
                    phase_nxt = SCAN_ON;
                end else begin
                    phase_nxt = SCAN_BLANK;
                end
            end
            SCAN_ON: begin
                if (slot_end) begin
                    cnt_nxt   = '0;
                    phase_nxt = SCAN_BLANK;
                    if (digit == DW'(DIGITS - 1)) begin
                        digit_nxt = '0;
                    end else begin
                        digit_nxt = digit + DW'(1);
                    end
                end else begin
                    phase_nxt = SCAN_ON;
                end
            end
            default: begin
                cnt_nxt   = '0;
                phase_nxt = SCAN_BLANK;
                digit_nxt = '0;
            end
        endcase
    end

    // Slot counter, phase and digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= SCAN_BLANK;
            digit <= '0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            digit <= digit_nxt;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode driver for the game's 4-digit segment frame.
// Frames arrive over valid/ready into a shadow buffer and are copied into the
// active buffer only at the scan-frame boundary, so a frame is never shown
// half old / half new. Every digit slot starts with a blank phase to suppress
// ghosting between digits.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   frm_valid    producer has a frame on frm_data
//   frm_ready    shadow buffer empty
//   frm_data     {map3,...,map0}; byte i drives digit i (digit 0 rightmost)
//   seg_n        active-low segments of the lit digit, 8'hFF when blank
//   an_n         active-low anode select, at most one bit low
//   frame_swap   one-cycle pulse in the first blank cycle after a swap
//   scan_digit   index of the current slot
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 64,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frm_valid,
    output logic                  frm_ready,
    input  logic [DIGITS*8-1:0]   frm_data,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_swap,
    output logic [DW-1:0]         scan_digit
);

    scan_state_e        phase;
    scan_state_e        phase_nxt;
    logic [DW-1:0]      digit;
    logic [DW-1:0]      digit_nxt;
    logic               slot_end;
    logic               frame_end;
    logic               boundary;

    logic [DIGITS*8-1:0] shadow;
    logic                shadow_full;
    logic [7:0]          active_buf [DIGITS];

    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          seg_nxt;

    seg_scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .phase_nxt (phase_nxt),
        .digit     (digit),
        .digit_nxt (digit_nxt),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // frame_end already implies the other two terms; spelling them out keeps
    // the boundary condition readable on its own.
    assign boundary   = frame_end && slot_end && (phase == SCAN_ON);
    assign frm_ready  = ~shadow_full;
    assign scan_digit = digit;

    // Output decode for the next cycle, so an_n/seg_n register in step with the phase.
    // During BLANK the active buffer may be mid-swap; it is never read then.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        if (phase_nxt == SCAN_ON) begin
            an_nxt[digit_nxt] = 1'b0;
            seg_nxt           = active_buf[digit_nxt];
        end else begin
            an_nxt  = '1;
            seg_nxt = SEG_BLANK;
        end
    end

    // Frame buffers, handshake state and registered display outputs.
    // A boundary with a full shadow takes priority: the shadow cannot accept
    // a new frame in the same cycle it is being emptied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                active_buf[i] <= SEG_BLANK;
            end
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            frame_swap <= 1'b0;
        end else begin
            frame_swap <= 1'b0;
            if (boundary && shadow_full) begin
                for (int i = 0; i < DIGITS; i++) begin
                    active_buf[i] <= shadow[8*i +: 8];
                end
                shadow_full <= 1'b0;
                frame_swap  <= 1'b1;
            end else if (frm_valid && frm_ready) begin
                shadow      <= frm_data;
                shadow_full <= 1'b1;
            end else begin
                shadow_full <= shadow_full;
            end
            an_n  <= an_nxt;
            seg_n <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// The reference model tracks the number of clock edges since reset release and
// derives slot, phase and digit from it arithmetically; frames move through a
// one-entry shadow and a 4-byte active array at 32-cycle boundaries.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int SDIV   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SDIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frm_valid = 1'b0;
    logic        frm_ready;
    logic [31:0] frm_data = 32'h0;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_swap;
    logic [1:0]  scan_digit;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int          t;
    bit          m_full;
    logic [31:0] m_shadow;
    logic [7:0]  m_active [4];
    bit          m_swap;
    bit          accepted;

    seg_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SDIV),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_swap (frame_swap),
        .scan_digit (scan_digit)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_an();
        if ((t % SDIV) < BLANK) return 4'hF;
        return ~(4'b0001 << ((t / SDIV) % DIGITS));
    endfunction

    function automatic logic [7:0] exp_seg();
        if ((t % SDIV) < BLANK) return 8'hFF;
        return m_active[(t / SDIV) % DIGITS];
    endfunction

    function automatic logic [1:0] exp_digit();
        return 2'((t / SDIV) % DIGITS);
    endfunction

    task automatic model_reset();
        t = 0;
        m_full = 1'b0;
        m_swap = 1'b0;
        accepted = 1'b0;
        for (int i = 0; i < 4; i++) m_active[i] = 8'hFF;
    endtask

    // Advance one clock; the model applies the same edge's rules first.
    task automatic step();
        bit swap_next;
        swap_next = 1'b0;
        accepted = 1'b0;
        if ((t % FRAME) == FRAME - 1 && m_full) begin
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[8*i +: 8];
            m_full = 1'b0;
            swap_next = 1'b1;
        end else if (frm_valid && !m_full) begin
            m_shadow = frm_data;
            m_full = 1'b1;
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
        m_swap = swap_next;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        frm_valid = 1'b0;
        model_reset();
    endtask

    // Let any pending frame swap out so the shadow is empty.
    task automatic drain();
        int guard;
        frm_valid = 1'b0;
        guard = 0;
        while (m_full && guard < 80) begin step(); guard++; end
        checks++;
        if (m_full) begin errors++; $display("FAIL drain_timeout got full=1 exp full=0"); end
    endtask

    task automatic test_reset();
        int guard;
        frm_valid = 1'b1; frm_data = $urandom; step(); frm_valid = 1'b0;
        guard = 0;
        while ((t % SDIV) < 4 && guard < 20) begin step(); guard++; end
        checks++;
        if (an_n !== exp_an()) begin errors++; $display("FAIL pre_reset_an got %h exp %h", an_n, exp_an()); end
        checks++;
        if (frm_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready got %b exp 0", frm_ready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp f", an_n); end
        checks++;
        if (seg_n !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp ff", seg_n); end
        checks++;
        if (frm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", frm_ready); end
        checks++;
        if (frame_swap !== 1'b0) begin errors++; $display("FAIL reset_swap got %b exp 0", frame_swap); end
        checks++;
        if (scan_digit !== 2'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", scan_digit); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (an_n !== exp_an() || seg_n !== exp_seg() || scan_digit !== exp_digit())
            begin errors++; $display("FAIL post_reset t=%0d got an=%h seg=%h dig=%0d exp an=%h seg=%h dig=%0d", t, an_n, seg_n, scan_digit, exp_an(), exp_seg(), exp_digit()); end
        end
    endtask

    task automatic test_load_display();
        logic [7:0] glyph [4];
        int guard;
        glyph[0] = 8'h73; glyph[1] = 8'h75; glyph[2] = 8'h77; glyph[3] = 8'hA3;
        drain();
        frm_valid = 1'b1; frm_data = 32'hA3777573;
        guard = 0;
        do begin step(); guard++; end while (!accepted && guard < 80);
        frm_valid = 1'b0;
        guard = 0;
        while (!m_swap && guard < 80) begin
            step(); guard++;
            checks++;
            if (frame_swap !== m_swap) begin errors++; $display("FAIL load_swap_wait t=%0d got %b exp %b", t, frame_swap, m_swap); end
        end
        checks++;
        if (frame_swap !== 1'b1 || (t % FRAME) != 0) begin errors++; $display("FAIL load_swap got %b exp 1 at t=%0d", frame_swap, t); end
        for (int i = 0; i < FRAME; i++) begin
            int pos, dig;
            pos = t % SDIV; dig = (t / SDIV) % DIGITS;
            checks++;
            if (pos < BLANK) begin
                if (an_n !== 4'hF || seg_n !== 8'hFF) begin errors++; $display("FAIL load_blank t=%0d got an=%h seg=%h exp an=f seg=ff", t, an_n, seg_n); end
            end else begin
                if (an_n !== ~(4'b0001 << dig) || seg_n !== glyph[dig]) begin errors++; $display("FAIL load_on t=%0d got an=%h seg=%h exp an=%h seg=%h", t, an_n, seg_n, ~(4'b0001 << dig), glyph[dig]); end
            end
            step();
        end
    endtask

    task automatic test_timing();
        int blank_run, last_swap, swaps, guard;
        guard = 0;
        while ((t % SDIV) != 0 && guard < 10) begin step(); guard++; end
        blank_run = 0; last_swap = -1; swaps = 0;
        for (int i = 0; i < 96; i++) begin
            if (!frm_valid) begin frm_valid = 1'b1; frm_data = $urandom; end
            checks++;
            if ($countones(~an_n) > 1) begin errors++; $display("FAIL timing_onehot t=%0d got an=%b exp at most one 0", t, an_n); end
            if (an_n === 4'hF) blank_run++;
            else begin
                if (blank_run != 0) begin
                    checks++;
                    if (blank_run != BLANK) begin errors++; $display("FAIL timing_blank t=%0d got %0d exp %0d", t, blank_run, BLANK); end
                end
                blank_run = 0;
            end
            if (frame_swap === 1'b1) begin
                if (last_swap >= 0) begin
                    checks++;
                    if (((t - last_swap) % FRAME) != 0) begin errors++; $display("FAIL timing_swap_spacing got %0d exp multiple of %0d", t - last_swap, FRAME); end
                end
                last_swap = t; swaps++;
            end
            checks++;
            if (an_n !== exp_an() || seg_n !== exp_seg() || frame_swap !== m_swap || frm_ready !== !m_full)
            begin errors++; $display("FAIL timing_model t=%0d got an=%h seg=%h sw=%b rdy=%b exp an=%h seg=%h sw=%b rdy=%b", t, an_n, seg_n, frame_swap, frm_ready, exp_an(), exp_seg(), m_swap, !m_full); end
            step();
            if (accepted) frm_valid = 1'b0;
        end
        frm_valid = 1'b0;
        checks++;
        if (swaps < 2) begin errors++; $display("FAIL timing_swap_count got %0d exp >=2", swaps); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f2;
        int guard, swap_t;
        drain();
        guard = 0;
        while ((t % FRAME) != 1 && guard < 40) begin step(); guard++; end
        frm_valid = 1'b1; frm_data = $urandom; step();
        checks++;
        if (!accepted || frm_ready !== 1'b0) begin errors++; $display("FAIL b2b_f1_accept got rdy=%b exp 0", frm_ready); end
        f2 = $urandom; frm_data = f2;
        guard = 0;
        while (frm_ready !== 1'b1 && guard < 80) begin
            checks++;
            if (frm_ready !== !m_full) begin errors++; $display("FAIL b2b_ready t=%0d got %b exp %b", t, frm_ready, !m_full); end
            step(); guard++;
        end
        checks++;
        if (frame_swap !== 1'b1 || (t % FRAME) != 0) begin errors++; $display("FAIL b2b_ready_rise t=%0d got swap=%b exp 1", t, frame_swap); end
        swap_t = t;
        step();
        checks++;
        if (!accepted) begin errors++; $display("FAIL b2b_f2_accept got 0 exp 1"); end
        frm_valid = 1'b0;
        guard = 0;
        while (frame_swap !== 1'b1 && guard < 80) begin step(); guard++; end
        checks++;
        if (t - swap_t != FRAME) begin errors++; $display("FAIL b2b_f2_swap got %0d exp %0d", t - swap_t, FRAME); end
        step(); step();
        checks++;
        if (seg_n !== f2[7:0] || an_n !== 4'b1110) begin errors++; $display("FAIL b2b_f2_show got an=%h seg=%h exp an=e seg=%h", an_n, seg_n, f2[7:0]); end
    endtask

    task automatic test_boundary_collision();
        logic [31:0] d;
        int guard;
        drain();
        guard = 0;
        while ((t % FRAME) != FRAME - 1 && guard < 40) begin step(); guard++; end
        d = $urandom;
        frm_valid = 1'b1; frm_data = d;
        step();
        frm_valid = 1'b0;
        checks++;
        if (frame_swap !== 1'b0 || frm_ready !== 1'b0) begin errors++; $display("FAIL coll_boundary got swap=%b rdy=%b exp swap=0 rdy=0", frame_swap, frm_ready); end
        for (int i = 0; i < FRAME - 1; i++) begin
            step();
            checks++;
            if (frame_swap !== 1'b0) begin errors++; $display("FAIL coll_early_swap t=%0d got 1 exp 0", t); end
        end
        step();
        checks++;
        if (frame_swap !== 1'b1) begin errors++; $display("FAIL coll_swap got %b exp 1", frame_swap); end
        step(); step();
        checks++;
        if (seg_n !== d[7:0] || an_n !== 4'b1110) begin errors++; $display("FAIL coll_show got an=%h seg=%h exp an=e seg=%h", an_n, seg_n, d[7:0]); end
    endtask

    task automatic test_reset_shadow_full();
        int guard;
        drain();
        guard = 0;
        while ((t % FRAME) != 2 && guard < 40) begin step(); guard++; end
        frm_valid = 1'b1; frm_data = $urandom; step(); frm_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            checks++;
            if (seg_n !== 8'hFF || frame_swap !== 1'b0 || frm_ready !== 1'b1) begin errors++; $display("FAIL rsf_idle t=%0d got seg=%h sw=%b rdy=%b exp seg=ff sw=0 rdy=1", t, seg_n, frame_swap, frm_ready); end
            step();
        end
        frm_valid = 1'b1; frm_data = $urandom;
        for (int i = 0; i < 80; i++) begin
            step();
            if (accepted) frm_valid = 1'b0;
            checks++;
            if (an_n !== exp_an() || seg_n !== exp_seg() || frame_swap !== m_swap)
            begin errors++; $display("FAIL rsf_load t=%0d got an=%h seg=%h sw=%b exp an=%h seg=%h sw=%b", t, an_n, seg_n, frame_swap, exp_an(), exp_seg(), m_swap); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!frm_valid && $urandom_range(0, 5) == 0) begin frm_valid = 1'b1; frm_data = $urandom; end
            step();
            if (accepted) frm_valid = 1'b0;
            checks++;
            if (an_n !== exp_an() || seg_n !== exp_seg() || frame_swap !== m_swap || frm_ready !== !m_full || scan_digit !== exp_digit())
            begin errors++; $display("FAIL random t=%0d got an=%h seg=%h sw=%b rdy=%b dig=%0d exp an=%h seg=%h sw=%b rdy=%b dig=%0d", t, an_n, seg_n, frame_swap, frm_ready, scan_digit, exp_an(), exp_seg(), m_swap, !m_full, exp_digit()); end
        end
        frm_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        checks++;
        if (an_n !== 4'hF || seg_n !== 8'hFF || frm_ready !== 1'b1 || frame_swap !== 1'b0 || scan_digit !== 2'd0)
        begin errors++; $display("FAIL init_state got an=%h seg=%h rdy=%b sw=%b dig=%0d exp an=f seg=ff rdy=1 sw=0 dig=0", an_n, seg_n, frm_ready, frame_swap, scan_digit); end
        test_reset();
        test_load_display();
        test_timing();
        test_back_to_back();
        test_boundary_collision();
        test_reset_shadow_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
